// File: rtl/flex_counter_pkg.sv
// Purpose : shared types and default sizes for the multi-channel flex counter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: cnt_dir_t (count direction), cnt_mode_t (end-of-range behaviour), default widths.
package flex_counter_pkg;

   localparam int DEF_NUM_CNT_BITS = 4;
   localparam int DEF_NUM_CH       = 2;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } cnt_dir_t;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } cnt_mode_t;

endpackage

// File: rtl/flex_counter_ch.sv
// Purpose : one flex counter channel (up/down, load, wrap or saturate, terminal flag, wrap pulse).
// Latency : every input reaches the registered outputs one clock later; no comb in->out path.
// Backpressure: none; every edge is evaluated as clear > load > enable > hold.
// Ports   : clk/n_rst; i_clear, i_load, i_count_enable, i_dir, i_mode; i_load_val,
//           i_rollover_val (terminal value N); o_count, o_rollover_flag, o_wrap_pulse.
module flex_counter_ch
   import flex_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS = DEF_NUM_CNT_BITS
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    i_clear,
   input  logic                    i_load,
   input  logic                    i_count_enable,
   input  cnt_dir_t                i_dir,
   input  cnt_mode_t               i_mode,
   input  logic [NUM_CNT_BITS-1:0] i_load_val,
   input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
   output logic [NUM_CNT_BITS-1:0] o_count,
   output logic                    o_rollover_flag,
   output logic                    o_wrap_pulse
);

   localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

   logic [NUM_CNT_BITS-1:0] r_cnt;
   logic                    r_flag;
   logic                    r_pulse;

   logic [NUM_CNT_BITS-1:0] w_cnt_nxt;
   logic [NUM_CNT_BITS-1:0] w_term;
   logic                    w_flag_nxt;
   logic                    w_pulse_nxt;

   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_flag_nxt  = r_flag;
      w_pulse_nxt = 1'b0;
      w_term      = i_rollover_val;

      if (i_clear) begin
         w_cnt_nxt  = '0;
         w_flag_nxt = 1'b0;
      end else if (i_load) begin
         w_cnt_nxt  = i_load_val;
         w_flag_nxt = 1'b0;
      end else if (i_count_enable) begin
         if (i_rollover_val == '0) begin
            // N==0 is a degenerate channel: it never moves and never flags.
            w_flag_nxt = 1'b0;
         end else begin
            if (i_dir == DIR_UP) begin
               w_term = i_rollover_val;
               // >= rather than == so a count loaded above N still wraps instead of running away.
               if (r_cnt >= i_rollover_val) begin
                  if (i_mode == MODE_WRAP) begin
                     w_cnt_nxt   = ONE;
                     w_pulse_nxt = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + ONE;
               end
            end else begin
               w_term = ONE;
               // <= catches count 0 (after clear/reset) as well as 1.
               if (r_cnt <= ONE) begin
                  if (i_mode == MODE_WRAP) begin
                     w_cnt_nxt   = i_rollover_val;
                     w_pulse_nxt = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - ONE;
               end
            end
            w_flag_nxt = (w_cnt_nxt == w_term);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cnt   <= '0;
         r_flag  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_flag  <= w_flag_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   assign o_count         = r_cnt;
   assign o_rollover_flag = r_flag;
   assign o_wrap_pulse    = r_pulse;

endmodule

// File: rtl/flex_counter_mc.sv
// Purpose : NUM_CH independent flex counters on one clock/reset, plus an OR of their terminal flags.
// Latency : one clock from any input to count_out/rollover_flag/wrap_pulse; any_rollover follows the flag regs.
// Backpressure: none; each channel steps whenever its count_enable is high.
// Ports   : clk, n_rst; per-channel clear/load/count_enable/count_up/sat_mode vectors;
//           packed load_val, rollover_val, count_out; rollover_flag, wrap_pulse vectors; any_rollover.
module flex_counter_mc
   import flex_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS = DEF_NUM_CNT_BITS,
   parameter int NUM_CH       = DEF_NUM_CH
) (
   input  logic                                 clk,
   input  logic                                 n_rst,
   input  logic [NUM_CH-1:0]                    clear,
   input  logic [NUM_CH-1:0]                    load,
   input  logic [NUM_CH-1:0]                    count_enable,
   input  logic [NUM_CH-1:0]                    count_up,
   input  logic [NUM_CH-1:0]                    sat_mode,
   input  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  load_val,
   input  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  rollover_val,
   output logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  count_out,
   output logic [NUM_CH-1:0]                    rollover_flag,
   output logic [NUM_CH-1:0]                    wrap_pulse,
   output logic                                 any_rollover
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      cnt_dir_t  w_dir;
      cnt_mode_t w_mode;

      assign w_dir  = count_up[g] ? DIR_UP   : DIR_DOWN;
      assign w_mode = sat_mode[g] ? MODE_SAT : MODE_WRAP;

      flex_counter_ch #(
         .NUM_CNT_BITS (NUM_CNT_BITS)
      ) u_ch (
         .clk             (clk),
         .n_rst           (n_rst),
         .i_clear         (clear[g]),
         .i_load          (load[g]),
         .i_count_enable  (count_enable[g]),
         .i_dir           (w_dir),
         .i_mode          (w_mode),
         .i_load_val      (load_val[g]),
         .i_rollover_val  (rollover_val[g]),
         .o_count         (count_out[g]),
         .o_rollover_flag (rollover_flag[g]),
         .o_wrap_pulse    (wrap_pulse[g])
      );
   end

   assign any_rollover = |rollover_flag;

endmodule
